// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial add/subtract unit.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   function automatic int calc_steps(input int width, input int digit);
      return width / digit;
   endfunction

   // Step counter needs at least one bit even when a single step suffices.
   function automatic int cnt_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder cell composed of two half adders.
module FullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic s0, c0, c1;

   HalfAdder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
   HalfAdder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

   assign c_o = c0 | c1;

endmodule

// File: rtl/HalfAdder.sv
// Single-bit half adder cell.
module HalfAdder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/adder_slice.sv
// W-bit ripple-carry slice; also exposes the carry into its top bit for overflow detection.
module adder_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         c_msb_in
);

   logic [W:0] c;

   assign c[0] = cin;

   // Every bit carries a b operand and a ripple carry, so every cell is a full adder.
   for (genvar i = 0; i < W; i++) begin : g_bit
      FullAdder u_fa (
         .a_i(a[i]),
         .b_i(b[i]),
         .c_i(c[i]),
         .s_o(sum[i]),
         .c_o(c[i+1])
      );
   end

   assign cout     = c[W];
   assign c_msb_in = c[W-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands consumed DIGIT bits per clock, LSB first,
// with valid/ready handshakes on both sides and carry/borrow plus signed overflow.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   ans,
   output logic             ovf
);

   localparam int STEPS = calc_steps(WIDTH, DIGIT);
   localparam int CW    = cnt_width(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $fatal(1, "serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH:0]   ans_q, ans_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT-1:0]       dsum;
   logic                   dcout, dcmsb;
   logic [WIDTH+DIGIT-1:0] res_cat;
   logic [WIDTH-1:0]       res_next;

   adder_slice #(.W(DIGIT)) u_slice (
      .a       (a_q[DIGIT-1:0]),
      .b       (b_q[DIGIT-1:0]),
      .cin     (carry_q),
      .sum     (dsum),
      .cout    (dcout),
      .c_msb_in(dcmsb)
   );

   // New digit enters at the MSB end so the full result lines up after STEPS shifts.
   assign res_cat  = {dsum, res_q};
   assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      ans_d   = ans_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = sub ? ~B : B;
               sub_d   = sub;
               carry_d = sub;
               cnt_d   = '0;
               res_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dcout;
            res_d   = res_next;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               // Subtraction carry-out is inverted so ans[WIDTH] reads as borrow.
               ans_d   = {sub_q ? ~dcout : dcout, res_next};
               ovf_d   = dcmsb ^ dcout;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ans_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         ans_q   <= ans_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign ans       = ans_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT = 1, 4, 16) driven by directed and random
// stimulus; a negedge monitor predicts every output from plain arithmetic and a result queue.
module tb_serial_adder;

   localparam int W     = 16;
   localparam int NI    = 3;
   localparam int LIMIT = 60000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         iv [NI];
   logic         ir [NI];
   logic         ov [NI];
   logic         ordy [NI];
   logic         sb [NI];
   logic         ovf [NI];
   logic [W-1:0] a [NI];
   logic [W-1:0] b [NI];
   logic [W:0]   ans [NI];

   for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int D = (k == 0) ? 1 : (k == 1) ? 4 : 16;
      serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (iv[k]),
         .in_ready (ir[k]),
         .A        (a[k]),
         .B        (b[k]),
         .sub      (sb[k]),
         .out_valid(ov[k]),
         .out_ready(ordy[k]),
         .ans      (ans[k]),
         .ovf      (ovf[k])
      );
   end

   function automatic int digit_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 16;
   endfunction

   // Reference: {ovf, carry/borrow, result} from integer arithmetic on the operand values.
   function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y, input logic s);
      int unsigned ux, uy;
      int          sx, sy, sr;
      logic [16:0] r;
      logic        o;
      ux = x;
      uy = y;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!s) begin
         r  = 17'(ux + uy);
         sr = sx + sy;
      end else begin
         r[15:0] = 16'(ux - uy);
         r[16]   = (ux < uy);
         sr      = sx - sy;
      end
      o = (sr > 32767) || (sr < -32768);
      return {o, r};
   endfunction

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int tmo    = 0;
   bit done   = 0;
   bit started = 0;
   bit          busy [NI];
   int          since [NI];
   logic [17:0] hold [NI];
   logic [17:0] q [NI][$];

   function automatic void chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (DIGIT=%0d) t=%0t actual=%0h required=%0h", nm, digit_of(k), $time, act, exp);
      end
   endfunction

   // Monitor: first compare outputs against the predicted state, then advance the
   // prediction using the inputs that the next rising edge will sample.
   always @(negedge clk) begin
      logic e_ov;
      cyc++;
      if (started) begin
         for (int k = 0; k < NI; k++) begin
            e_ov = busy[k] && (since[k] >= W / digit_of(k));
            chk("in_ready", k, 32'(ir[k]), 32'(!busy[k]));
            chk("out_valid", k, 32'(ov[k]), 32'(e_ov));
            if (e_ov) begin
               chk("ans", k, 32'(ans[k]), 32'(q[k][0][16:0]));
               chk("ovf", k, 32'(ovf[k]), 32'(q[k][0][17]));
            end else begin
               chk("ans_hold", k, 32'(ans[k]), 32'(hold[k][16:0]));
               chk("ovf_hold", k, 32'(ovf[k]), 32'(hold[k][17]));
            end
         end
      end
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            busy[k]  = 1'b0;
            since[k] = 0;
            hold[k]  = '0;
            q[k].delete();
         end else if (started) begin
            if (busy[k] && since[k] >= W / digit_of(k) && ordy[k]) begin
               hold[k] = q[k].pop_front();
               busy[k] = 1'b0;
            end else if (!busy[k] && iv[k]) begin
               q[k].push_back(ref_op(a[k], b[k], sb[k]));
               busy[k]  = 1'b1;
               since[k] = 0;
            end else if (busy[k]) begin
               since[k]++;
            end
         end
      end
      if (rst) started = 1'b1;
      if (done || cyc > LIMIT) begin
         if (!done) begin
            checks++;
            errors++;
            $display("FAIL watchdog: stimulus still running at cycle %0d, required done by %0d", cyc, LIMIT);
         end
         chk("timeouts", 0, 32'(tmo), 32'd0);
         for (int k = 0; k < NI; k++) chk("drained", k, 32'(busy[k]), 32'd0);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   task automatic op(input int k, input logic [15:0] x, input logic [15:0] y, input logic s, input int bp);
      int n;
      a[k]  = x;
      b[k]  = y;
      sb[k] = s;
      iv[k] = 1'b1;
      n = 0;
      while (!ir[k] && n < 200) begin @(posedge clk); #1; n++; end
      if (!ir[k]) tmo++;
      @(posedge clk); #1;
      // With backpressure requested, keep offering fresh operands that must be ignored.
      if (bp == 0) iv[k] = 1'b0;
      n = 0;
      while (!ov[k] && n < 200) begin
         a[k]  = 16'($urandom);
         b[k]  = 16'($urandom);
         sb[k] = 1'($urandom);
         @(posedge clk); #1;
         n++;
      end
      if (!ov[k]) tmo++;
      repeat (bp) begin
         a[k] = 16'($urandom);
         b[k] = 16'($urandom);
         @(posedge clk); #1;
      end
      ordy[k] = 1'b1;
      iv[k]   = 1'b0;
      @(posedge clk); #1;
      ordy[k] = 1'b0;
   endtask

   task automatic mid_reset(input int k);
      int n;
      a[k]  = 16'($urandom);
      b[k]  = 16'($urandom);
      sb[k] = 1'($urandom);
      iv[k] = 1'b1;
      n = 0;
      while (!ir[k] && n < 200) begin @(posedge clk); #1; n++; end
      if (!ir[k]) tmo++;
      @(posedge clk); #1;
      iv[k] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 16'hFFFF;
         1:       return 16'h8000;
         2:       return 16'h7FFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; sb[k] = 1'b0; a[k] = '0; b[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      op(1, 16'hFFFF, 16'h0001, 1'b0, 0);
      op(1, 16'h0003, 16'h0005, 1'b1, 0);
      op(1, 16'h7FFF, 16'h0001, 1'b0, 0);
      op(1, 16'h8000, 16'h0001, 1'b1, 0);
      op(1, 16'h1234, 16'h4321, 1'b0, 10);
      op(1, 16'h0F0F, 16'hF0F0, 1'b1, 0);
      mid_reset(1);
      op(1, 16'h8001, 16'h7FFF, 1'b1, 0);
      for (int k = 0; k < NI; k++) begin
         mid_reset(k);
         repeat (340) op(k, pick_operand(), pick_operand(), 1'($urandom), $urandom_range(0, 3));
      end
      repeat (4) begin @(posedge clk); #1; end
      done = 1'b1;
   end

endmodule
